// File: rtl/matrix_io_ctrl.sv
// matrix_io_ctrl: loads A/B operands element-wise, runs the 5x5 matrix ALU, drains the result.
module matrix_io_ctrl #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 25,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ELEM_W-1:0]        cmd_esc,
  input  logic [ELEM_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ELEM_W*N_ELEM-1:0] mat_a,
  output logic [ELEM_W*N_ELEM-1:0] mat_b,
  output logic [ELEM_W-1:0]        esc,
  output logic [1:0]               op,
  output logic                     ula_en,
  input  logic                     ula_done,
  input  logic [ELEM_W*N_ELEM-1:0] ula_mat,
  input  logic                     ula_ovf,
  output logic [ELEM_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_ovf,
  output logic                     busy,
  output logic                     err
);
  localparam int MW = ELEM_W * N_ELEM;
  localparam int KW = $clog2(N_ELEM);
  localparam logic [KW-1:0] K_LAST = KW'(N_ELEM - 1);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WAIT, DRAIN} state_t;
  state_t state_q;
  logic [KW-1:0] cnt_q;
  logic [MW-1:0] res_q;
  logic k_last;
  assign k_last    = cnt_q == K_LAST;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign in_ready  = state_q == LOAD_A || state_q == LOAD_B;
  assign out_valid = state_q == DRAIN;
  assign out_last  = out_valid && k_last;
  assign out_data  = res_q[cnt_q*ELEM_W +: ELEM_W];
`ifdef EXEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mat_a   <= '0;
      mat_b   <= '0;
      res_q   <= '0;
      esc     <= '0;
      op      <= '0;
      ula_en  <= 1'b0;
      out_ovf <= 1'b0;
`ifdef EXEC_TIMEOUT_EN
      tmo_q   <= '0;
      err     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          op      <= cmd_op;
          esc     <= cmd_esc;
          mat_b   <= '0;
          cnt_q   <= '0;
          state_q <= LOAD_A;
`ifdef EXEC_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        LOAD_A, LOAD_B: if (in_valid) begin
          if (state_q == LOAD_A) mat_a[cnt_q*ELEM_W +: ELEM_W] <= in_data;
          else mat_b[cnt_q*ELEM_W +: ELEM_W] <= in_data;
          cnt_q <= k_last ? '0 : cnt_q + 1'b1;
          if (k_last) state_q <= (state_q == LOAD_B || op == 2'b10) ? EXEC : LOAD_B;
        end
        EXEC: begin
          ula_en <= 1'b1;
          if (ula_en && ula_done) begin
            ula_en  <= 1'b0;
            state_q <= WAIT;
          end
`ifdef EXEC_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            ula_en  <= 1'b0;
            err     <= 1'b1;
            state_q <= IDLE;
          end
          tmo_q <= tmo_q + 1'b1;
`endif
        end
        WAIT: begin
          res_q   <= ula_mat;
          out_ovf <= ula_ovf;
          state_q <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          cnt_q <= k_last ? '0 : cnt_q + 1'b1;
          if (k_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
